// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage between execute and writeback.
// Handles loads, stores and pass-through operations. Sub-word lanes are
// big-endian, and misaligned accesses trap without starting a bus cycle.
// Optional feature macro: MEM_TIMEOUT_EN adds a bus watchdog that aborts
// the cycle after TIMEOUT BUS cycles and reports cause 11.
module mem_access_unit #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [AW-1:0]     adr_i,
  input  logic [DW-1:0]     data_i,
  input  logic [3:0]        rd_i,
  input  logic              wr_i,
  input  logic              stall_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic [DW-1:0]     result_o,
  output logic              reg_write_o,
  output logic [3:0]        reg_write_addr_o,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o,
  output logic              bus_cyc,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [AW-1:0]     bus_adr,
  output logic [DW/8-1:0]   bus_sel,
  output logic [DW-1:0]     bus_out,
  input  logic [DW-1:0]     bus_in,
  input  logic              bus_ack,
  input  logic              bus_err
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned BW = $clog2(NB) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_HOLD} state_t;

  // Access size in bytes for a size_i encoding.
  function automatic logic [BW-1:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b01:   return BW'(2);
      2'b10:   return BW'(1);
      2'b11:   return BW'(4);
      default: return BW'(NB);
    endcase
  endfunction

  // Big-endian lane enables: byte offset k maps to lane NB-1-k.
  function automatic logic [NB-1:0] lane_sel(input logic [OW-1:0] off,
                                             input logic [BW-1:0] nb);
    logic [NB-1:0] s;
    int hi;
    int lo;
    s  = '0;
    hi = int'(NB) - 1 - int'(off);
    lo = hi - int'(nb) + 1;
    for (int i = 0; i < int'(NB); i++) begin
      if (i >= lo && i <= hi) s[i] = 1'b1;
    end
    return s;
  endfunction

  // Store data replicated across every lane group of the access size.
  function automatic logic [DW-1:0] replicate(input logic [DW-1:0] d,
                                              input logic [BW-1:0] nb);
    logic [DW-1:0] r;
    int m;
    m = int'(nb) - 1;
    for (int i = 0; i < int'(NB); i++) begin
      r[8*i +: 8] = d[8*(i & m) +: 8];
    end
    return r;
  endfunction

  // Right-justify the addressed lanes and sign- or zero-extend.
  function automatic logic [DW-1:0] extract(input logic [DW-1:0] d,
                                            input logic [OW-1:0] off,
                                            input logic [BW-1:0] nb,
                                            input logic          sx);
    logic [DW-1:0] sh;
    logic [DW-1:0] r;
    logic          sb;
    int n;
    n  = int'(nb);
    sh = d >> (8 * (int'(NB) - n - int'(off)));
    sb = sx & sh[8*n-1];
    for (int i = 0; i < int'(NB); i++) begin
      r[8*i +: 8] = (i < n) ? sh[8*i +: 8] : {8{sb}};
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   result_q, result_d;
  logic            rw_q, rw_d;
  logic [3:0]      rwa_q, rwa_d;
  logic            exc_q, exc_d;
  logic [1:0]      cause_q, cause_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   badr_q, badr_d;
  logic [NB-1:0]   sel_q, sel_d;
  logic [DW-1:0]   bout_q, bout_d;
  logic            ld_q, ld_d;
  logic            sx_q, sx_d;
  logic [OW-1:0]   off_q, off_d;
  logic [BW-1:0]   nb_q, nb_d;
  logic            wr_q, wr_d;
  logic [3:0]      rd_q, rd_d;
  logic [DW-1:0]   h_result_q, h_result_d;
  logic            h_exc_q, h_exc_d;
  logic [1:0]      h_cause_q, h_cause_d;
  logic            h_wr_q, h_wr_d;

  // Completion of the current bus cycle, before deciding present vs. hold.
  logic            fin;
  logic [DW-1:0]   r_res;
  logic            r_exc;
  logic [1:0]      r_cause;
  logic            r_wr;

  logic [OW-1:0]   in_off;
  logic [BW-1:0]   in_nb;
  logic            misaligned;

  assign in_off     = adr_i[OW-1:0];
  assign in_nb      = size_bytes(size_i);
  assign misaligned = (in_off & OW'(in_nb - BW'(1))) != '0;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 255) ? 16 : 8;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   cnt_inc;
  assign cnt_inc = cnt_q + TW'(1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    rw_d       = rw_q;
    rwa_d      = rwa_q;
    exc_d      = exc_q;
    cause_d    = cause_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    badr_d     = badr_q;
    sel_d      = sel_q;
    bout_d     = bout_q;
    ld_d       = ld_q;
    sx_d       = sx_q;
    off_d      = off_q;
    nb_d       = nb_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    h_result_d = h_result_q;
    h_exc_d    = h_exc_q;
    h_cause_d  = h_cause_q;
    h_wr_d     = h_wr_q;
    fin        = 1'b0;
    r_res      = result_q;
    r_exc      = 1'b0;
    r_cause    = 2'b00;
    r_wr       = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (valid_i && !stall_i) begin
          if (!load_i && !store_i) begin
            valid_d  = 1'b1;
            result_d = DW'(adr_i);
            rw_d     = wr_i;
            rwa_d    = rd_i;
            exc_d    = 1'b0;
            cause_d  = 2'b00;
          end else if (misaligned) begin
            valid_d  = 1'b1;
            rw_d     = 1'b0;
            rwa_d    = rd_i;
            exc_d    = 1'b1;
            cause_d  = 2'b01;
          end else begin
            state_d  = S_BUS;
            cyc_d    = 1'b1;
            we_d     = store_i;
            badr_d   = adr_i;
            sel_d    = lane_sel(in_off, in_nb);
            bout_d   = replicate(data_i, in_nb);
            ld_d     = load_i;
            sx_d     = signed_i;
            off_d    = in_off;
            nb_d     = in_nb;
            wr_d     = wr_i & load_i & ~store_i;
            rd_d     = rd_i;
`ifdef MEM_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end

      S_BUS: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        if (bus_err) begin
          fin     = 1'b1;
          r_exc   = 1'b1;
          r_cause = 2'b10;
        end else if (bus_ack) begin
          fin     = 1'b1;
          r_wr    = wr_q;
          r_res   = ld_q ? extract(bus_in, off_q, nb_q, sx_q) : result_q;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_inc == TW'(TIMEOUT)) begin
          fin     = 1'b1;
          r_exc   = 1'b1;
          r_cause = 2'b11;
        end
`endif
        if (fin) begin
          cyc_d = 1'b0;
          if (!stall_i) begin
            state_d  = S_IDLE;
            valid_d  = 1'b1;
            result_d = r_res;
            rw_d     = r_wr;
            rwa_d    = rd_q;
            exc_d    = r_exc;
            cause_d  = r_cause;
          end else begin
            state_d    = S_HOLD;
            h_result_d = r_res;
            h_exc_d    = r_exc;
            h_cause_d  = r_cause;
            h_wr_d     = r_wr;
          end
        end
      end

      S_HOLD: begin
        if (!stall_i) begin
          state_d  = S_IDLE;
          valid_d  = 1'b1;
          result_d = h_result_q;
          rw_d     = h_wr_q;
          rwa_d    = rd_q;
          exc_d    = h_exc_q;
          cause_d  = h_cause_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any bus cycle in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      result_q   <= '0;
      rw_q       <= 1'b0;
      rwa_q      <= '0;
      exc_q      <= 1'b0;
      cause_q    <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      badr_q     <= '0;
      sel_q      <= '0;
      bout_q     <= '0;
      ld_q       <= 1'b0;
      sx_q       <= 1'b0;
      off_q      <= '0;
      nb_q       <= '0;
      wr_q       <= 1'b0;
      rd_q       <= '0;
      h_result_q <= '0;
      h_exc_q    <= 1'b0;
      h_cause_q  <= '0;
      h_wr_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      rw_q       <= rw_d;
      rwa_q      <= rwa_d;
      exc_q      <= exc_d;
      cause_q    <= cause_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      badr_q     <= badr_d;
      sel_q      <= sel_d;
      bout_q     <= bout_d;
      ld_q       <= ld_d;
      sx_q       <= sx_d;
      off_q      <= off_d;
      nb_q       <= nb_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      h_result_q <= h_result_d;
      h_exc_q    <= h_exc_d;
      h_cause_q  <= h_cause_d;
      h_wr_q     <= h_wr_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign stall_o          = (state_q != S_IDLE) | stall_i;
  assign valid_o          = valid_q;
  assign result_o         = result_q;
  assign reg_write_o      = rw_q;
  assign reg_write_addr_o = rwa_q;
  assign exc_o            = exc_q;
  assign exc_cause_o      = cause_q;
  assign bus_cyc          = cyc_q;
  assign bus_stb          = cyc_q;
  assign bus_we           = we_q;
  assign bus_adr          = badr_q;
  assign bus_sel          = sel_q;
  assign bus_out          = bout_q;

endmodule
